crc32_frame_checker: RTL and testbench
======================================

Name: crc32_frame_checker

Overview:
Receive-side counterpart of the CRC32 generator peripheral. Accepts a byte stream frame whose last 4 bytes are a transmitted CRC32, computes the CRC over the payload with the same configurable engine semantics (poly, RefIn, Init, XorOut), and reports pass/fail. It sits between a byte source (UART/PMOD deserialiser or bus FIFO) and the peripheral register file, which reads the result and status.

Parameters:
DEFAULT_POLY, 32'h04C11DB7, polynomial used when `cfg_poly_ld` has never been pulsed since reset.
MIN_PAYLOAD, 1, minimum payload bytes; a frame shorter than MIN_PAYLOAD+4 bytes is a length error.

Ports:
clk  in  1  Clock; all logic on the rising edge.
rst  in  1  Synchronous active-high reset.
in_data  in  8  Frame byte.
in_valid  in  1  Byte present.
in_last  in  1  Qualifies the final byte of the frame.
in_ready  out  1  Byte accepted when `in_valid && in_ready`.
abort  in  1  Discard the current frame.
cfg_refin  in  1  Reflect each input byte and the final CRC.
cfg_xorout  in  1  XOR the final CRC with 32'hFFFFFFFF.
cfg_init  in  1  1: CRC seed 32'hFFFFFFFF; 0: seed 32'h0.
cfg_poly  in  32  Polynomial value.
cfg_poly_ld  in  1  Load `cfg_poly` into the polynomial register.
result_valid  out  1  One-cycle pulse when a frame verdict is ready.
crc_ok  out  1  Computed CRC equals received CRC.
len_err  out  1  Frame was too short.
crc_calc  out  32  Final computed CRC after reflect/xor.
crc_rx  out  32  Received CRC; first of the last 4 bytes is bits [7:0].

Behaviour:
- Reset values: in_ready=0, result_valid=0, crc_ok=0, len_err=0, crc_calc=0, crc_rx=0; polynomial register = DEFAULT_POLY; FSM in IDLE. in_ready rises the first cycle after rst is deasserted.
- FSM states: IDLE, COLLECT, SHIFT, FINAL, REPORT.
- IDLE: in_ready=1. On the first accepted byte, the block latches cfg_refin, cfg_xorout and cfg_init for the whole frame, loads the CRC seed, and moves to COLLECT. Later config changes do not affect the frame.
- 4-byte delay window (shift register plus a 3-bit fill count): each accepted byte is pushed into the window.
  - If the window already held 4 bytes, the oldest byte is evicted into the CRC engine and the FSM enters SHIFT.
  - Otherwise the FSM stays in COLLECT with in_ready=1.
- SHIFT: bit-serial MSB-first CRC update (refin: byte bit-reversed first). Exactly 8 cycles, with in_ready=0 throughout. Then returns to COLLECT, or to FINAL if the last byte has already been accepted.
- Byte count: a 16-bit byte counter saturates at 16'hFFFF.
- in_last accepted with count < MIN_PAYLOAD+4: go directly to REPORT with len_err=1, crc_ok=0, crc_calc=0; crc_rx = window contents.
- FINAL (1 cycle): crc_calc = optional bit-reverse of all 32 bits (refin), then optional XOR (xorout). crc_rx is assembled from the window.
- REPORT (1 cycle): result_valid=1, then IDLE.
- Result outputs hold until the next REPORT.
- Latency: the final verdict pulse comes 10 cycles after acceptance of a last byte that evicts (8 SHIFT + FINAL + REPORT).
- Backpressure: in_valid may be held with in_ready=0; data is not sampled.
- abort: in any state other than IDLE, the FSM returns to IDLE next cycle, the window is cleared, and no result pulse is generated. Abort takes priority over a same-cycle byte accept.
- cfg_poly_ld: takes effect immediately only in IDLE. Otherwise it is held pending and applied on return to IDLE.
- rst mid-frame: all state reverts to reset values, including the polynomial.

Optional Feature:
Macro CRC_CHK_STATS_EN.
- When defined: adds outputs `good_cnt[15:0]` and `bad_cnt[15:0]`, each reset to 0.
  - good_cnt increments on each REPORT with crc_ok=1.
  - bad_cnt increments on each REPORT with crc_ok=0 (including len_err).
  - Both counters saturate at 16'hFFFF.
  - Input `stats_clr` zeroes both counters; a clear coincident with an increment yields 0.
- When not defined: these ports and their logic are absent.

Test Plan:
- CRC-32 check. Config refin=1, xorout=1, init=1, poly 04C11DB7. Send bytes "123456789" then 26 39 F4 CB (last). Expect result_valid pulse 10 cycles after last accept, crc_calc=32'hCBF43926, crc_rx=32'hCBF43926, crc_ok=1, len_err=0.
- CRC-32/MPEG-2. Config refin=0, xorout=0, init=1. Send "123456789" then E7 E6 76 03. Expect crc_calc=32'h0376E6E7, crc_ok=1. Flip payload byte '5' to '6': expect crc_ok=0, crc_rx=32'h0376E6E7.
- Short frame. Send 4 bytes with last on the 4th. Expect len_err=1, crc_ok=0, result pulse with no SHIFT cycles.
- Backpressure/timing.
  - in_valid held high continuously: in_ready stays 1 for the first 4 accepts.
  - in_ready is then 0 for exactly 8 cycles after each subsequent accept.
  - No byte is duplicated or dropped (compare against the golden CRC).
- Abort and reset. Assert abort during SHIFT of byte 6, then send a valid frame: only the second frame reports, and it is correct. Assert rst mid-frame: all outputs return to reset values and in_ready=0 during rst.
- With CRC_CHK_STATS_EN:
  - 2 good frames + 1 bad frame: good_cnt=2, bad_cnt=1.
  - stats_clr coincident with a REPORT: both counters read 0.

Source files
------------

// File: rtl/crc32_frame_checker.sv
// crc32_frame_checker
//   Receive-side CRC32 frame checker. A frame is a byte stream whose last four
//   bytes carry the transmitted CRC32 (first of those bytes = bits [7:0]).
//   The payload runs through a bit-serial MSB-first CRC engine with the
//   configurable poly / RefIn / Init / XorOut semantics of the generator
//   peripheral. A pass/fail verdict is then reported as a one-cycle pulse.
//
//   A 4-byte delay window keeps the trailing CRC bytes out of the engine. A
//   byte reaches the engine only when a newer byte pushes it out of the
//   window.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   in_data/valid/last   byte stream input, in_ready = accept handshake
//   abort                drop the current frame, no verdict
//   cfg_refin/xorout/init  per-frame engine config, latched on first byte
//   cfg_poly, cfg_poly_ld  polynomial load (deferred while a frame is open)
//   result_valid         one-cycle verdict pulse
//   crc_ok, len_err      verdict flags (held until next verdict)
//   crc_calc, crc_rx     computed / received CRC (held until next verdict)
//
// Optional build macro CRC_CHK_STATS_EN adds stats_clr, good_cnt, bad_cnt:
//   saturating counts of passing / failing verdicts.
module crc32_frame_checker #(
  parameter logic [31:0] DEFAULT_POLY = 32'h04C11DB7,
  parameter int          MIN_PAYLOAD  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        abort,
  input  logic        cfg_refin,
  input  logic        cfg_xorout,
  input  logic        cfg_init,
  input  logic [31:0] cfg_poly,
  input  logic        cfg_poly_ld,
  output logic        result_valid,
  output logic        crc_ok,
  output logic        len_err,
  output logic [31:0] crc_calc,
  output logic [31:0] crc_rx
`ifdef CRC_CHK_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
`endif
);

  localparam logic [16:0] MIN_LEN = 17'(MIN_PAYLOAD + 4);

  typedef enum logic [2:0] {IDLE, COLLECT, SHIFT, FINAL, REPORT} state_t;

  state_t      state;
  logic [31:0] poly, poly_pend;
  logic        pend;
  logic        refin_q, xorout_q;
  logic [31:0] crc;
  logic [31:0] win;        // newest byte at [31:24], oldest at [7:0]
  logic [2:0]  fill;
  logic [15:0] cnt;
  logic        last_seen;
  logic [7:0]  sh;         // byte being shifted into the engine, MSB first
  logic [2:0]  bitcnt;

  logic        accept;
  logic [15:0] cnt_inc;
  logic        too_short;
  logic [31:0] win_push;
  logic [31:0] crc_bit;
  logic [31:0] crc_fin;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  always_comb begin
    accept    = in_valid && in_ready;
    // count including the byte being accepted this cycle
    cnt_inc   = (state == IDLE) ? 16'd1 :
                (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    too_short = ({1'b0, cnt_inc} < MIN_LEN);
    // a new frame starts from an empty window
    win_push  = (state == IDLE) ? {in_data, 24'h0} : {in_data, win[31:8]};
    crc_bit   = {crc[30:0], 1'b0} ^ ((crc[31] ^ sh[7]) ? poly : 32'h0);
    crc_fin   = (refin_q ? rev32(crc) : crc) ^ (xorout_q ? 32'hFFFFFFFF : 32'h0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      result_valid <= 1'b0;
      crc_ok       <= 1'b0;
      len_err      <= 1'b0;
      crc_calc     <= 32'h0;
      crc_rx       <= 32'h0;
      poly         <= DEFAULT_POLY;
      poly_pend    <= 32'h0;
      pend         <= 1'b0;
      refin_q      <= 1'b0;
      xorout_q     <= 1'b0;
      crc          <= 32'h0;
      win          <= 32'h0;
      fill         <= 3'd0;
      cnt          <= 16'd0;
      last_seen    <= 1'b0;
      sh           <= 8'h0;
      bitcnt       <= 3'd0;
    end else begin
      result_valid <= 1'b0;

      // Polynomial changes never disturb an open frame.
      if (state == IDLE) begin
        if (cfg_poly_ld)  poly <= cfg_poly;
        else if (pend)    poly <= poly_pend;
        pend <= 1'b0;
      end else if (cfg_poly_ld) begin
        poly_pend <= cfg_poly;
        pend      <= 1'b1;
      end

      if (abort && state != IDLE) begin
        state     <= IDLE;
        in_ready  <= 1'b1;
        win       <= 32'h0;
        fill      <= 3'd0;
        cnt       <= 16'd0;
        last_seen <= 1'b0;
      end else begin
        case (state)
          IDLE, COLLECT: begin
            in_ready <= 1'b1;
            if (accept) begin
              if (state == IDLE) begin
                refin_q  <= cfg_refin;
                xorout_q <= cfg_xorout;
                crc      <= cfg_init ? 32'hFFFFFFFF : 32'h0;
              end
              win       <= win_push;
              cnt       <= cnt_inc;
              last_seen <= in_last;
              if (in_last && too_short) begin
                // no engine work for a runt frame
                state        <= REPORT;
                in_ready     <= 1'b0;
                result_valid <= 1'b1;
                len_err      <= 1'b1;
                crc_ok       <= 1'b0;
                crc_calc     <= 32'h0;
                crc_rx       <= win_push;
              end else if (state == COLLECT && fill == 3'd4) begin
                // window full: oldest byte goes to the engine
                sh       <= refin_q ? rev8(win[7:0]) : win[7:0];
                bitcnt   <= 3'd0;
                state    <= SHIFT;
                in_ready <= 1'b0;
              end else begin
                fill  <= fill + 3'd1;
                state <= COLLECT;
                if (in_last) begin
                  // empty payload allowed only when MIN_PAYLOAD is 0
                  state    <= FINAL;
                  in_ready <= 1'b0;
                end
              end
            end
          end
          SHIFT: begin
            crc    <= crc_bit;
            sh     <= {sh[6:0], 1'b0};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              if (last_seen) begin
                state <= FINAL;
              end else begin
                state    <= COLLECT;
                in_ready <= 1'b1;
              end
            end
          end
          FINAL: begin
            crc_calc     <= crc_fin;
            crc_rx       <= win;
            crc_ok       <= (crc_fin == win);
            len_err      <= 1'b0;
            result_valid <= 1'b1;
            state        <= REPORT;
          end
          REPORT: begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            fill      <= 3'd0;
            cnt       <= 16'd0;
            last_seen <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef CRC_CHK_STATS_EN
  // Counted in the REPORT cycle, where crc_ok already holds the verdict.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      good_cnt <= 16'd0;
      bad_cnt  <= 16'd0;
    end else if (state == REPORT) begin
      if (crc_ok) begin
        if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
      end else begin
        if (bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_crc32_frame_checker.sv
// Self-checking bench for crc32_frame_checker: table of standard CRC-32
// catalogue vectors, hand sequences for timing / abort / reset / polynomial
// deferral, and randomized frames against a byte-wise reference CRC model.
module tb_crc32_frame_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid, in_last, in_ready, abort;
  logic        cfg_refin, cfg_xorout, cfg_init, cfg_poly_ld;
  logic [31:0] cfg_poly;
  logic        result_valid, crc_ok, len_err;
  logic [31:0] crc_calc, crc_rx;
`ifdef CRC_CHK_STATS_EN
  logic        stats_clr;
  logic [15:0] good_cnt, bad_cnt;
`endif

  crc32_frame_checker dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .abort(abort),
    .cfg_refin(cfg_refin), .cfg_xorout(cfg_xorout), .cfg_init(cfg_init),
    .cfg_poly(cfg_poly), .cfg_poly_ld(cfg_poly_ld),
    .result_valid(result_valid), .crc_ok(crc_ok), .len_err(len_err),
    .crc_calc(crc_calc), .crc_rx(crc_rx)
`ifdef CRC_CHK_STATS_EN
    , .stats_clr(stats_clr), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int pulses = 0;
  always @(negedge clk) if (result_valid) pulses <= pulses + 1;

  int pass_cnt = 0;
  int total    = 0;
  int last_acc;
  int acc_log[$];

  typedef struct {
    logic [15:0][7:0] data;
    int               len;
    bit               ri, xo, in;
    logic [31:0]      exp_calc, exp_rx;
    bit               chk_calc, exp_ok, exp_le;
    int               exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: textbook byte-at-a-time CRC; reflected variants use the
  // right-shifting form with the mirrored polynomial.
  function automatic logic [31:0] model_crc(input logic [15:0][7:0] d, input int n,
                                            input bit ri, input bit xo, input bit in,
                                            input logic [31:0] p);
    logic [31:0] c, rp;
    c = in ? 32'hFFFFFFFF : 32'h0;
    for (int k = 0; k < 32; k++) rp[k] = p[31-k];
    for (int i = 0; i < n; i++) begin
      if (ri) begin
        c ^= {24'h0, d[i]};
        for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ rp) : (c >> 1);
      end else begin
        c ^= {d[i], 24'h0};
        for (int b = 0; b < 8; b++) c = c[31] ? ((c << 1) ^ p) : (c << 1);
      end
    end
    return xo ? ~c : c;
  endfunction

  function automatic vec_t mk(input string p, input logic [31:0] tail,
                              input bit ri, input bit xo, input bit in,
                              input logic [31:0] ec, input bit cc,
                              input bit ok, input bit le, input int lat);
    vec_t v;
    v.data = '0;
    for (int i = 0; i < p.len(); i++) v.data[i] = p[i];
    for (int k = 0; k < 4; k++) v.data[p.len()+k] = tail[8*k +: 8];
    v.len = p.len() + 4;
    v.ri = ri; v.xo = xo; v.in = in;
    v.exp_calc = ec; v.exp_rx = tail; v.chk_calc = cc;
    v.exp_ok = ok; v.exp_le = le; v.exp_lat = lat;
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit last);
    int n;
    in_valid = 1'b1;
    in_last  = last;
    n = 0;
    // garbage on in_data while stalled must never be sampled
    while (!in_ready && n < 60) begin
      in_data = 8'($urandom);
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("ready_timeout", 32'd1, 32'd0);
    in_data = b;
    @(negedge clk);
    last_acc = cyc;
    acc_log.push_back(cyc);
  endtask

  task automatic run_frame(input logic [15:0][7:0] d, input int len,
                           input bit ri, input bit xo, input bit in, input int gap_pct,
                           output int lat, output bit got);
    int n;
    cfg_refin = ri; cfg_xorout = xo; cfg_init = in;
    for (int i = 0; i < len; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      send_byte(d[i], i == len - 1);
      if (i == 0) begin
        // frame config is latched; later changes must not matter
        cfg_refin  = 1'($urandom);
        cfg_xorout = 1'($urandom);
        cfg_init   = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    n = 0;
    while (!result_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    got = result_valid;
    lat = cyc - last_acc + 1;
  endtask

  int          lat, bad, pb, len, elat;
  bit          got, ri, xo, in, ok;
  logic [15:0][7:0] d;
  logic [31:0] mpoly, calc, tl, erx;
  string       s;

  initial begin
    rst = 1'b1; in_data = 8'h0; in_valid = 1'b0; in_last = 1'b0; abort = 1'b0;
    cfg_refin = 1'b0; cfg_xorout = 1'b0; cfg_init = 1'b0;
    cfg_poly = 32'h0; cfg_poly_ld = 1'b0;
`ifdef CRC_CHK_STATS_EN
    stats_clr = 1'b0;
`endif

    vecs[0] = mk("123456789", 32'hCBF43926, 1, 1, 1, 32'hCBF43926, 1, 1, 0, 10);
    vecs[1] = mk("123456789", 32'h0376E6E7, 0, 0, 1, 32'h0376E6E7, 1, 1, 0, 10);
    vecs[2] = mk("123466789", 32'h0376E6E7, 0, 0, 1, 32'h0, 0, 0, 0, 10);
    vecs[3] = mk("123456789", 32'hFC891918, 0, 1, 1, 32'hFC891918, 1, 1, 0, 10);
    vecs[4] = mk("123456789", 32'h340BC6D9, 1, 0, 1, 32'h340BC6D9, 1, 1, 0, 10);
    vecs[5] = mk("123456789", 32'h765E7680, 0, 1, 0, 32'h765E7680, 1, 1, 0, 10);
    vecs[6] = mk("", 32'h44332211, 1, 1, 1, 32'h0, 1, 0, 1, 1);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_crc_ok", crc_ok, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_crc_calc", crc_calc, 0);
    chk("rst_crc_rx", crc_rx, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);

    // table vectors
    foreach (vecs[i]) begin
      run_frame(vecs[i].data, vecs[i].len, vecs[i].ri, vecs[i].xo, vecs[i].in, 25, lat, got);
      chk($sformatf("v%0d_pulse", i), got, 1);
      if (vecs[i].chk_calc) chk($sformatf("v%0d_calc", i), crc_calc, vecs[i].exp_calc);
      chk($sformatf("v%0d_rx", i), crc_rx, vecs[i].exp_rx);
      chk($sformatf("v%0d_ok", i), crc_ok, vecs[i].exp_ok);
      chk($sformatf("v%0d_len_err", i), len_err, vecs[i].exp_le);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      @(negedge clk);
      chk($sformatf("v%0d_one_cycle", i), result_valid, 0);
    end

    // back-to-back bytes: 5 consecutive accepts, then one every 9 cycles
    acc_log.delete();
    run_frame(vecs[0].data, vecs[0].len, 1, 1, 1, 0, lat, got);
    bad = 0;
    for (int i = 1; i < acc_log.size(); i++)
      if (acc_log[i] - acc_log[i-1] != ((i <= 4) ? 1 : 9)) bad++;
    chk("bp_accept_spacing", bad, 0);
    chk("bp_ok", crc_ok, 1);
    chk("bp_calc", crc_calc, 32'hCBF43926);
    @(negedge clk);

    // abort while shifting, then a good frame: exactly one verdict
    s = "123456";
    cfg_refin = 1; cfg_xorout = 1; cfg_init = 1;
    for (int i = 0; i < 6; i++) send_byte(s[i], 0);
    in_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    pb = pulses;
    run_frame(vecs[0].data, vecs[0].len, 1, 1, 1, 0, lat, got);
    chk("abort_ok", crc_ok, 1);
    chk("abort_calc", crc_calc, 32'hCBF43926);
    @(negedge clk);
    chk("abort_pulses", pulses - pb, 1);

    // polynomial load mid-frame is deferred to the next frame
    fork
      run_frame(vecs[0].data, vecs[0].len, 1, 1, 1, 0, lat, got);
      begin
        repeat (8) @(negedge clk);
        cfg_poly = 32'h1EDC6F41; cfg_poly_ld = 1'b1;
        @(negedge clk);
        cfg_poly_ld = 1'b0;
      end
    join
    chk("poly_defer_old", crc_calc, 32'hCBF43926);
    @(negedge clk);
    d = mk("123456789", 32'hE3069283, 1, 1, 1, 0, 0, 0, 0, 0).data;
    run_frame(d, 13, 1, 1, 1, 0, lat, got);
    chk("poly_new_calc", crc_calc, 32'hE3069283);
    chk("poly_new_ok", crc_ok, 1);
    @(negedge clk);

    // reset mid-frame: outputs cleared, polynomial back to default
    for (int i = 0; i < 7; i++) send_byte(vecs[0].data[i], 0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_crc_calc", crc_calc, 0);
    chk("mid_rst_crc_rx", crc_rx, 0);
    chk("mid_rst_crc_ok", crc_ok, 0);
    rst = 1'b0;
    @(negedge clk);
    run_frame(vecs[0].data, vecs[0].len, 1, 1, 1, 0, lat, got);
    chk("post_rst_default_poly", crc_calc, 32'hCBF43926);
    chk("post_rst_ok", crc_ok, 1);
    @(negedge clk);

`ifdef CRC_CHK_STATS_EN
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    run_frame(vecs[0].data, vecs[0].len, 1, 1, 1, 0, lat, got);
    @(negedge clk);
    run_frame(vecs[1].data, vecs[1].len, 0, 0, 1, 0, lat, got);
    @(negedge clk);
    run_frame(vecs[2].data, vecs[2].len, 0, 0, 1, 0, lat, got);
    @(negedge clk);
    chk("stats_good", good_cnt, 2);
    chk("stats_bad", bad_cnt, 1);
    run_frame(vecs[0].data, vecs[0].len, 1, 1, 1, 0, lat, got);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    chk("stats_clr_good", good_cnt, 0);
    chk("stats_clr_bad", bad_cnt, 0);
`endif

    // randomized frames against the reference model
    mpoly = 32'h04C11DB7;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(3) == 0) begin
        mpoly = $urandom;
        cfg_poly = mpoly; cfg_poly_ld = 1'b1;
        @(negedge clk);
        cfg_poly_ld = 1'b0;
      end
      len = $urandom_range(16, 1);
      for (int i = 0; i < 16; i++) d[i] = 8'($urandom);
      ri = 1'($urandom); xo = 1'($urandom); in = 1'($urandom);
      if (len >= 5) begin
        calc = model_crc(d, len - 4, ri, xo, in, mpoly);
        tl = ($urandom_range(1) == 1) ? calc : (calc ^ (32'h1 << $urandom_range(31)));
        for (int k = 0; k < 4; k++) d[len-4+k] = tl[8*k +: 8];
        erx = tl; ok = (tl == calc); elat = 10;
      end else begin
        calc = 32'h0; erx = 32'h0; ok = 0; elat = 1;
        for (int i = 0; i < len; i++) erx = {d[i], erx[31:8]};
      end
      run_frame(d, len, ri, xo, in, 30, lat, got);
      chk($sformatf("r%0d_pulse", t), got, 1);
      chk($sformatf("r%0d_calc", t), crc_calc, calc);
      chk($sformatf("r%0d_rx", t), crc_rx, erx);
      chk($sformatf("r%0d_ok", t), crc_ok, ok);
      chk($sformatf("r%0d_len_err", t), len_err, (len < 5) ? 1 : 0);
      chk($sformatf("r%0d_latency", t), lat, elat);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
